// File: rtl/sephirot_rf_pkg.sv
// Shared definitions for the sephirot register file: log2 helpers, FSM encoding
// and the default geometry that the LVT and the bank read datapath agree on.
package sephirot_rf_pkg;

    localparam int MEMD_DEF  = 16;
    localparam int DATAW_DEF = 64;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    function automatic int rf_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index widths never collapse to zero bits, even for a single port.
    function automatic int rf_log2_min1(input int n);
        int r;
        r = rf_log2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rf_bank_ram.sv
// Single-write, single-read synchronous RAM with registered output and
// old-data read-during-write behaviour on a shared address.
module rf_bank_ram
    import sephirot_rf_pkg::*;
#(
    parameter int MEMD  = MEMD_DEF,
    parameter int DATAW = DATAW_DEF
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [rf_log2(MEMD)-1:0]  waddr,
    input  logic [DATAW-1:0]          wdata,
    input  logic [rf_log2(MEMD)-1:0]  raddr,
    output logic [DATAW-1:0]          rdata
);

    logic [DATAW-1:0] mem [MEMD];

    // The read samples mem before this edge's write lands: old-data semantics.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lvt_bank_read.sv
// Read-side datapath of the LVT multi-ported register file plus the post-reset
// clear sequencer. Define SEPHIROT_LVT_BYPASS_EN for new-data write-to-read bypass.
module lvt_bank_read
    import sephirot_rf_pkg::*;
#(
    parameter int MEMD    = MEMD_DEF,
    parameter int DATAW   = DATAW_DEF,
    parameter int nRPORTS = 2,
    parameter int nWPORTS = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [nWPORTS-1:0]                       WEnb,
    input  logic [rf_log2(MEMD)*nWPORTS-1:0]         WAddr,
    input  logic [DATAW*nWPORTS-1:0]                 WData,
    input  logic [rf_log2(MEMD)*nRPORTS-1:0]         RAddr,
    input  logic [rf_log2_min1(nWPORTS)*nRPORTS-1:0] RBank,
    output logic [nWPORTS-1:0]                       LvtWEnb,
    output logic [rf_log2(MEMD)*nWPORTS-1:0]         LvtWAddr,
    output logic [DATAW*nRPORTS-1:0]                 RData,
    output logic [nRPORTS-1:0]                       RValid,
    output logic                                     Busy
);

    localparam int ADDRW  = rf_log2(MEMD);
    localparam int LVTW   = rf_log2_min1(nWPORTS);
    localparam int NBANKS = nWPORTS * nRPORTS;

    rf_state_e          state_q, state_d;
    logic [ADDRW-1:0]   cnt_q;
    logic               cnt_last;

    logic [nWPORTS-1:0]       bank_we;
    logic [ADDRW*nWPORTS-1:0] bank_waddr;
    logic [DATAW*nWPORTS-1:0] bank_wdata;
    logic [DATAW*NBANKS-1:0]  bank_q_p1;

    logic [nRPORTS-1:0] vld_p1;
    logic [DATAW-1:0]   rd_sel;
    logic [LVTW-1:0]    rd_bank;

    assign cnt_last = (cnt_q == ADDRW'(MEMD - 1));
    assign Busy     = (state_q == CLEAR);
    assign RValid   = vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) begin
                cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (cnt_last) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // Clear sweep owns every bank and LVT port 0; in RUN the lanes pass straight through.
    always_comb begin
        bank_we    = '0;
        bank_waddr = '0;
        bank_wdata = '0;
        LvtWEnb    = '0;
        LvtWAddr   = '0;
        if (state_q == CLEAR) begin
            bank_we = '1;
            for (int w = 0; w < nWPORTS; w++) begin
                bank_waddr[w*ADDRW +: ADDRW] = cnt_q;
            end
            LvtWEnb[0]          = !rst;
            LvtWAddr[ADDRW-1:0] = cnt_q;
        end else begin
            bank_we    = WEnb;
            bank_waddr = WAddr;
            bank_wdata = WData;
            LvtWEnb    = WEnb;
            LvtWAddr   = WAddr;
        end
    end

    // p0 -> p1: bank (w, r) sits at flat index w*nRPORTS + r
    for (genvar gw = 0; gw < nWPORTS; gw++) begin : g_wport
        for (genvar gr = 0; gr < nRPORTS; gr++) begin : g_rport
            rf_bank_ram #(
                .MEMD  (MEMD),
                .DATAW (DATAW)
            ) u_bank (
                .clk   (clk),
                .we    (bank_we[gw]),
                .waddr (bank_waddr[gw*ADDRW +: ADDRW]),
                .wdata (bank_wdata[gw*DATAW +: DATAW]),
                .raddr (RAddr[gr*ADDRW +: ADDRW]),
                .rdata (bank_q_p1[(gw*nRPORTS + gr)*DATAW +: DATAW])
            );
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= '0;
        end else begin
            vld_p1 <= {nRPORTS{state_q == RUN}};
        end
    end

`ifdef SEPHIROT_LVT_BYPASS_EN
    logic [nRPORTS-1:0]       byp_hit_p0, byp_hit_p1;
    logic [DATAW*nRPORTS-1:0] byp_data_p0, byp_data_p1;

    // Ascending scan so the highest-index matching write port wins.
    always_comb begin
        byp_hit_p0  = '0;
        byp_data_p0 = '0;
        for (int r = 0; r < nRPORTS; r++) begin
            for (int w = 0; w < nWPORTS; w++) begin
                if ((state_q == RUN) && WEnb[w] &&
                    (WAddr[w*ADDRW +: ADDRW] == RAddr[r*ADDRW +: ADDRW])) begin
                    byp_hit_p0[r]                  = 1'b1;
                    byp_data_p0[r*DATAW +: DATAW] = WData[w*DATAW +: DATAW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_hit_p1 <= '0;
        end else begin
            byp_hit_p1 <= byp_hit_p0;
        end
    end

    always_ff @(posedge clk) begin
        byp_data_p1 <= byp_data_p0;
    end
`endif

    // p1 output: out-of-range bank indices fall back to bank 0; gated by valid.
    always_comb begin
        RData   = '0;
        rd_sel  = '0;
        rd_bank = '0;
        for (int r = 0; r < nRPORTS; r++) begin
            rd_bank = RBank[r*LVTW +: LVTW];
            rd_sel  = bank_q_p1[r*DATAW +: DATAW];
            for (int w = 0; w < nWPORTS; w++) begin
                if (rd_bank == LVTW'(w)) begin
                    rd_sel = bank_q_p1[(w*nRPORTS + r)*DATAW +: DATAW];
                end
            end
`ifdef SEPHIROT_LVT_BYPASS_EN
            if (byp_hit_p1[r]) begin
                rd_sel = byp_data_p1[r*DATAW +: DATAW];
            end
`endif
            if (vld_p1[r]) begin
                RData[r*DATAW +: DATAW] = rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_lvt_bank_read.sv
// Directed self-checking bench for lvt_bank_read (MEMD=16, DATAW=64, 2R/2W).
module tb_lvt_bank_read;

    logic         clk;
    logic         rst;
    logic [1:0]   WEnb;
    logic [7:0]   WAddr;
    logic [127:0] WData;
    logic [7:0]   RAddr;
    logic [1:0]   RBank;
    logic [1:0]   LvtWEnb;
    logic [7:0]   LvtWAddr;
    logic [127:0] RData;
    logic [1:0]   RValid;
    logic         Busy;

    int checks;
    int errors;

    lvt_bank_read #(
        .MEMD    (16),
        .DATAW   (64),
        .nRPORTS (2),
        .nWPORTS (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .WEnb     (WEnb),
        .WAddr    (WAddr),
        .WData    (WData),
        .RAddr    (RAddr),
        .RBank    (RBank),
        .LvtWEnb  (LvtWEnb),
        .LvtWAddr (LvtWAddr),
        .RData    (RData),
        .RValid   (RValid),
        .Busy     (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (Busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy got %b want 1", Busy);
        end
        checks++;
        if (RValid !== 2'b00) begin
            errors++; $display("FAIL reset_rvalid got %b want 00", RValid);
        end
        checks++;
        if (RData !== 128'd0) begin
            errors++; $display("FAIL reset_rdata got %h want 0", RData);
        end
        checks++;
        if (LvtWEnb !== 2'b00) begin
            errors++; $display("FAIL reset_lvtwenb got %b want 00", LvtWEnb);
        end
    endtask

    task automatic check_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (Busy !== 1'b1 || LvtWEnb !== 2'b01 || LvtWAddr[3:0] !== 4'(i) || RValid !== 2'b00) begin
                errors++;
                $display("FAIL %s_sweep cycle %0d got busy=%b en=%b addr=%0d vld=%b want busy=1 en=01 addr=%0d vld=00",
                         tag, i, Busy, LvtWEnb, LvtWAddr[3:0], RValid, i);
            end
        end
        @(negedge clk);
        WEnb = 2'b00;
        checks++;
        if (Busy !== 1'b0 || RValid !== 2'b00) begin
            errors++;
            $display("FAIL %s_sweep_end got busy=%b vld=%b want busy=0 vld=00", tag, Busy, RValid);
        end
    endtask

    task automatic test_release();
        rst = 1'b0;
        #1;
        check_sweep("release");
    endtask

    task automatic test_first_read();
        RAddr = {4'd0, 4'd5};
        @(negedge clk);
        RBank = 2'b00;
        #1;
        checks++;
        if (RData[63:0] !== 64'd0 || RValid !== 2'b11) begin
            errors++;
            $display("FAIL first_read got data=%h vld=%b want data=0 vld=11", RData[63:0], RValid);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        WEnb  = 2'b10;
        WAddr = {4'd3, 4'd0};
        WData = {64'h0000_0000_DEAD_BEEF, 64'd0};
        #1;
        checks++;
        if (LvtWEnb !== 2'b10 || LvtWAddr !== 8'h30) begin
            errors++;
            $display("FAIL lvt_passthru got en=%b addr=%h want en=10 addr=30", LvtWEnb, LvtWAddr);
        end
        @(negedge clk);
        WEnb  = 2'b00;
        RAddr = {4'd0, 4'd3};
        @(negedge clk);
        RBank = 2'b01;
        #1;
        checks++;
        if (RData[63:0] !== 64'h0000_0000_DEAD_BEEF) begin
            errors++;
            $display("FAIL write_read got %h want 00000000deadbeef", RData[63:0]);
        end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        WEnb  = 2'b11;
        WAddr = {4'd7, 4'd7};
        WData = {64'h22, 64'h11};
        @(negedge clk);
        WEnb  = 2'b00;
        RAddr = {4'd7, 4'd7};
        @(negedge clk);
        RBank = 2'b01;
        #1;
        checks++;
        if (RData[63:0] !== 64'h22) begin
            errors++; $display("FAIL same_addr_lvt got %h want 22", RData[63:0]);
        end
        checks++;
        if (RData[127:64] !== 64'h11) begin
            errors++; $display("FAIL same_addr_bank0 got %h want 11", RData[127:64]);
        end
    endtask

    task automatic test_rdw();
        logic [63:0] exp_rdw;
`ifdef SEPHIROT_LVT_BYPASS_EN
        exp_rdw = 64'hAA;
`else
        exp_rdw = 64'h0;
`endif
        @(negedge clk);
        WEnb  = 2'b01;
        WAddr = {4'd0, 4'd2};
        WData = {64'd0, 64'hAA};
        RAddr = {4'd0, 4'd2};
        @(negedge clk);
        WEnb  = 2'b00;
        RBank = 2'b00;
        #1;
        checks++;
        if (RData[63:0] !== exp_rdw) begin
            errors++; $display("FAIL rdw_same_cycle got %h want %h", RData[63:0], exp_rdw);
        end
        @(negedge clk);
        #1;
        checks++;
        if (RData[63:0] !== 64'hAA) begin
            errors++; $display("FAIL rdw_after got %h want aa", RData[63:0]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        WEnb  = 2'b11;
        WAddr = {4'd10, 4'd9};
        WData = {64'h5678, 64'h1234};
        @(negedge clk);
        WEnb  = 2'b00;
        RAddr = {4'd10, 4'd9};
        @(negedge clk);
        RBank = 2'b10;
        #1;
        checks++;
        if (RData !== {64'h5678, 64'h1234}) begin
            errors++; $display("FAIL back_to_back got %h want 5678/1234", RData);
        end
    endtask

    task automatic test_reset_mid_clear();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (Busy !== 1'b1 || RValid !== 2'b00 || LvtWEnb !== 2'b00) begin
            errors++;
            $display("FAIL run_reset got busy=%b vld=%b en=%b want 1/00/00", Busy, RValid, LvtWEnb);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (LvtWAddr[3:0] !== 4'd9 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear_cnt got addr=%0d busy=%b want 9/1", LvtWAddr[3:0], Busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (Busy !== 1'b1 || LvtWEnb !== 2'b00) begin
            errors++;
            $display("FAIL mid_clear_rst got busy=%b en=%b want 1/00", Busy, LvtWEnb);
        end
        @(negedge clk);
        rst   = 1'b0;
        WEnb  = 2'b11;
        WAddr = {4'd4, 4'd4};
        WData = {128{1'b1}};
        RAddr = {4'd4, 4'd4};
        #1;
        check_sweep("restart");
    endtask

    task automatic test_cleared_reads();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            RAddr = {4'(a), 4'(a)};
            @(negedge clk);
            RBank = 2'b01;
            #1;
            checks++;
            if (RData !== 128'd0 || RValid !== 2'b11) begin
                errors++;
                $display("FAIL cleared_read addr %0d got data=%h vld=%b want 0/11", a, RData, RValid);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        WEnb   = '0;
        WAddr  = '0;
        WData  = '0;
        RAddr  = '0;
        RBank  = '0;
        test_reset();
        test_release();
        test_first_read();
        test_write_read();
        test_same_addr();
        test_rdw();
        test_back_to_back();
        test_reset_mid_clear();
        test_cleared_reads();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
